// File: rtl/pong_game_core.sv
// rtl/pong_game_core.sv - two-player Pong engine: paddles, ball, collisions, scoring, serve/win FSM
// Game state advances only on frame_tick; every output is driven straight from a flop.
module pong_game_core #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X1    = 32,
  parameter int PADDLE_X2    = 600,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               up1,
  input  logic               down1,
  input  logic               up2,
  input  logic               down2,
  output logic [9:0]         paddle1_y,
  output logic [9:0]         paddle2_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         state,
  output logic [1:0]         winner,
  output logic               point_pulse
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SERVE = 2'd1, ST_PLAY = 2'd2, ST_OVER = 2'd3} state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0]  PAD_MAX    = 10'(V_RES - PADDLE_H);
  localparam logic [9:0]  PAD_INIT   = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [9:0]  BALL_CX    = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_CY    = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  P_STEP     = 10'(PADDLE_STEP);
  localparam logic [9:0]  B_STEP     = 10'(BALL_STEP);
  localparam logic [9:0]  Y_MAX      = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0]  L_FACE     = 10'(PADDLE_X1 + PADDLE_W);
  localparam logic [9:0]  R_STOP     = 10'(PADDLE_X2 - BALL_SIZE);
  localparam logic [10:0] W_STEP     = 11'(BALL_STEP);
  localparam logic [10:0] W_SIZE     = 11'(BALL_SIZE);
  localparam logic [10:0] W_PADH     = 11'(PADDLE_H);
  localparam logic [10:0] W_VRES     = 11'(V_RES);
  localparam logic [10:0] W_HRES     = 11'(H_RES);
  localparam logic [10:0] W_X2       = 11'(PADDLE_X2);
  localparam logic [10:0] W_LFACE    = 11'(PADDLE_X1 + PADDLE_W);
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_t               state_q, state_d;
  logic [9:0]           pad1_q, pad1_d, pad2_q, pad2_d;
  logic [9:0]           ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic                 dx_q, dx_d, dy_q, dy_d;  // dx 1 = right, dy 1 = down
  logic [SCORE_W-1:0]   score1_q, score1_d, score2_q, score2_d;
  logic [1:0]           winner_q, winner_d;
  logic                 point_q, point_d;
  logic [CNT_W-1:0]     serve_cnt_q, serve_cnt_d;

  logic [10:0] bx_w, by_w, p1_w, p2_w;
  logic        ov1, ov2, left_hit, right_hit, miss_left, miss_right;
  logic [9:0]  x_nxt, y_nxt;
  logic        dx_nxt, dy_nxt;
  logic [SCORE_W-1:0] s1_inc, s2_inc;

  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] r;
    r = y;
    if (up && !dn)
      r = (y <= P_STEP) ? 10'd0 : y - P_STEP;
    else if (dn && !up)
      r = (y >= PAD_MAX - P_STEP) ? PAD_MAX : y + P_STEP;
    return r;
  endfunction

  // Collision tests work on 11-bit copies so edge sums never wrap.
  assign bx_w = {1'b0, ball_x_q};
  assign by_w = {1'b0, ball_y_q};
  assign p1_w = {1'b0, pad1_q};
  assign p2_w = {1'b0, pad2_q};

  assign ov1        = (by_w + W_SIZE > p1_w) && (by_w < p1_w + W_PADH);
  assign ov2        = (by_w + W_SIZE > p2_w) && (by_w < p2_w + W_PADH);
  assign left_hit   = !dx_q && (bx_w >= W_LFACE) && (bx_w <= W_LFACE + W_STEP) && ov1;
  assign right_hit  = dx_q && (bx_w + W_SIZE <= W_X2) && (bx_w + W_SIZE + W_STEP >= W_X2) && ov2;
  assign miss_left  = !dx_q && (ball_x_q < B_STEP);
  assign miss_right = dx_q && (bx_w + W_SIZE + W_STEP > W_HRES);
  assign s1_inc     = score1_q + SCORE_W'(1);
  assign s2_inc     = score2_q + SCORE_W'(1);

  always_comb begin
    y_nxt  = ball_y_q;
    dy_nxt = dy_q;
    if (!dy_q && ball_y_q <= B_STEP) begin
      y_nxt  = 10'd0;
      dy_nxt = 1'b1;
    end else if (dy_q && (by_w + W_SIZE + W_STEP >= W_VRES)) begin
      y_nxt  = Y_MAX;
      dy_nxt = 1'b0;
    end else if (dy_q) begin
      y_nxt = ball_y_q + B_STEP;
    end else begin
      y_nxt = ball_y_q - B_STEP;
    end

    x_nxt  = ball_x_q;
    dx_nxt = dx_q;
    if (left_hit) begin
      x_nxt  = L_FACE;
      dx_nxt = 1'b1;
    end else if (right_hit) begin
      x_nxt  = R_STOP;
      dx_nxt = 1'b0;
    end else if (dx_q) begin
      x_nxt = ball_x_q + B_STEP;
    end else begin
      x_nxt = ball_x_q - B_STEP;
    end
  end

  always_comb begin
    state_d     = state_q;
    pad1_d      = pad1_q;
    pad2_d      = pad2_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    point_d     = 1'b0;
    serve_cnt_d = serve_cnt_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d     = ST_SERVE;
          score1_d    = '0;
          score2_d    = '0;
          winner_d    = 2'd0;
          ball_x_d    = BALL_CX;
          ball_y_d    = BALL_CY;
          serve_cnt_d = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          pad1_d = paddle_next(pad1_q, up1, down1);
          pad2_d = paddle_next(pad2_q, up2, down2);
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          pad1_d = paddle_next(pad1_q, up1, down1);
          pad2_d = paddle_next(pad2_q, up2, down2);
          if (miss_left || miss_right) begin
            // Next serve heads toward the player who just conceded.
            point_d     = 1'b1;
            ball_x_d    = BALL_CX;
            ball_y_d    = BALL_CY;
            serve_cnt_d = '0;
            state_d     = ST_SERVE;
            if (miss_right) begin
              score1_d = s1_inc;
              dx_d     = 1'b1;
              if (s1_inc == WIN_S) begin
                state_d  = ST_OVER;
                winner_d = 2'd1;
              end
            end else begin
              score2_d = s2_inc;
              dx_d     = 1'b0;
              if (s2_inc == WIN_S) begin
                state_d  = ST_OVER;
                winner_d = 2'd2;
              end
            end
          end else begin
            ball_x_d = x_nxt;
            ball_y_d = y_nxt;
            dx_d     = dx_nxt;
            dy_d     = dy_nxt;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pad1_q      <= PAD_INIT;
      pad2_q      <= PAD_INIT;
      ball_x_q    <= BALL_CX;
      ball_y_q    <= BALL_CY;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= 2'd0;
      point_q     <= 1'b0;
      serve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pad1_q      <= pad1_d;
      pad2_q      <= pad2_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      point_q     <= point_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  assign paddle1_y   = pad1_q;
  assign paddle2_y   = pad2_q;
  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign state       = state_q;
  assign winner      = winner_q;
  assign point_pulse = point_q;

endmodule

// File: tb/tb_pong_game_core.sv
// tb/tb_pong_game_core.sv - scoreboard bench for pong_game_core (WIN_SCORE=2)
// Driver queues hand-computed expectations; a negedge monitor pops and compares them.
module tb_pong_game_core;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start, up1, down1, up2, down2;
  logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
  logic [3:0] score1, score2;
  logic [1:0] state, winner;
  logic       point_pulse;

  localparam int F_P1 = 0, F_P2 = 1, F_BX = 2, F_BY = 3, F_S1 = 4, F_S2 = 5,
                 F_ST = 6, F_WIN = 7, F_PP = 8;

  typedef struct {
    int    field;
    int    val;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic chk = 1'b0;

  pong_game_core #(.WIN_SCORE(2)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .up1(up1), .down1(down1), .up2(up2), .down2(down2),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .ball_x(ball_x), .ball_y(ball_y),
    .score1(score1), .score2(score2), .state(state), .winner(winner),
    .point_pulse(point_pulse)
  );

  always #5 clk = ~clk;

  function automatic int actual(int f);
    case (f)
      F_P1:    return int'(paddle1_y);
      F_P2:    return int'(paddle2_y);
      F_BX:    return int'(ball_x);
      F_BY:    return int'(ball_y);
      F_S1:    return int'(score1);
      F_S2:    return int'(score2);
      F_ST:    return int'(state);
      F_WIN:   return int'(winner);
      default: return int'(point_pulse);
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    int   act;
    if (chk) begin
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = actual(e.field);
        tests_run++;
        if (act != e.val) begin
          tests_failed++;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_f(input int f, input int v, input string n);
    exp_t e;
    e.field = f;
    e.val   = v;
    e.name  = n;
    sb_q.push_back(e);
  endtask

  task automatic expect_ball(input int x, input int y, input string n);
    expect_f(F_BX, x, {n, "_x"});
    expect_f(F_BY, y, {n, "_y"});
  endtask

  task automatic expect_all(input int p1, input int p2, input int bx, input int by, input int s1,
                            input int s2, input int st, input int w, input int pp, input string n);
    expect_f(F_P1, p1, {n, "_p1"});
    expect_f(F_P2, p2, {n, "_p2"});
    expect_ball(bx, by, n);
    expect_f(F_S1, s1, {n, "_s1"});
    expect_f(F_S2, s2, {n, "_s2"});
    expect_f(F_ST, st, {n, "_state"});
    expect_f(F_WIN, w, {n, "_winner"});
    expect_f(F_PP, pp, {n, "_pulse"});
  endtask

  task automatic check_now();
    chk = 1'b1;
    @(posedge clk);
    #1 chk = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic pulse_start(input logic with_tick);
    @(posedge clk);
    #1 start = 1'b1;
    frame_tick = with_tick;
    @(posedge clk);
    #1 start = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic serve_to_play(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == n - 1) begin expect_f(F_ST, 1, {tag, "_serving"}); check_now(); end
      if (k == n)     begin expect_f(F_ST, 2, {tag, "_play"});    check_now(); end
    end
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
    up1 = 1'b0; down1 = 1'b0; up2 = 1'b0; down2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    expect_all(208, 208, 316, 236, 0, 0, 0, 0, 0, "reset");
    check_now();

    up1 = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    up1 = 1'b0;
    expect_f(F_P1, 208, "idle_p1_frozen");
    expect_f(F_ST, 0, "idle_state");
    check_now();

    pulse_start(1'b0);
    expect_all(208, 208, 316, 236, 0, 0, 1, 0, 0, "start");
    check_now();
    serve_to_play(60, "serve1");

    // Rally 1: paddles clamp while the ball heads right, bounces off the floor and misses paddle 2.
    up1 = 1'b1; down2 = 1'b1;
    for (int k = 1; k <= 159; k++) begin
      if (k == 61) begin up1 = 1'b1; down1 = 1'b1; up2 = 1'b1; down2 = 1'b1; end
      if (k == 63) begin up1 = 1'b0; down1 = 1'b0; up2 = 1'b1; down2 = 1'b0; end
      if (k == 93) up2 = 1'b0;
      tick();
      if (k <= 60) begin
        expect_f(F_P1, (208 - 4 * k < 0) ? 0 : 208 - 4 * k, "r1_p1_up");
        expect_f(F_P2, (208 + 4 * k > 416) ? 416 : 208 + 4 * k, "r1_p2_down");
        if (k == 60) expect_ball(436, 356, "r1_t60");
        check_now();
      end
      if (k == 62) begin
        expect_f(F_P1, 0, "r1_p1_both"); expect_f(F_P2, 416, "r1_p2_both");
        expect_ball(440, 360, "r1_t62");
        check_now();
        pulse_start(1'b0);
        expect_f(F_ST, 2, "r1_start_ignored"); check_now();
      end
      if (k == 92)  begin expect_f(F_P2, 296, "r1_p2_up"); expect_ball(500, 420, "r1_t92"); check_now(); end
      if (k == 117) begin expect_ball(550, 470, "r1_t117"); check_now(); end
      if (k == 118) begin expect_ball(552, 472, "r1_floor"); check_now(); end
      if (k == 119) begin expect_ball(554, 470, "r1_after_floor"); check_now(); end
      if (k == 158) begin expect_ball(632, 392, "r1_t158"); check_now(); end
      if (k == 159) begin
        expect_all(0, 296, 316, 236, 1, 0, 1, 0, 1, "r1_point");
        check_now();
        expect_f(F_PP, 0, "r1_pulse_low"); check_now();
      end
    end

    pulse_start(1'b0);
    expect_f(F_ST, 1, "serve2_start_ignored"); expect_f(F_S1, 1, "serve2_s1"); check_now();
    serve_to_play(60, "serve2");

    // Rally 2: paddle 2 climbs to 0 and returns the ball; paddle 1 at 0 misses it low.
    up2 = 1'b1;
    for (int k = 1; k <= 435; k++) begin
      if (k == 75) up2 = 1'b0;
      tick();
      if (k == 1)   begin expect_ball(318, 234, "r2_t1"); check_now(); end
      if (k == 74)  begin expect_f(F_P2, 0, "r2_p2_top"); check_now(); end
      if (k == 117) begin expect_ball(550, 2, "r2_t117"); check_now(); end
      if (k == 118) begin expect_ball(552, 0, "r2_ceiling"); check_now(); end
      if (k == 119) begin expect_ball(554, 2, "r2_after_ceiling"); check_now(); end
      if (k == 137) begin expect_ball(590, 38, "r2_t137"); check_now(); end
      if (k == 138) begin expect_ball(592, 40, "r2_hit2"); check_now(); end
      if (k == 139) begin expect_ball(590, 42, "r2_after_hit2"); check_now(); end
      if (k == 354) begin expect_ball(160, 472, "r2_floor"); check_now(); end
      if (k == 434) begin expect_ball(0, 312, "r2_t434"); check_now(); end
      if (k == 435) begin expect_all(0, 0, 316, 236, 1, 1, 1, 0, 1, "r2_point"); check_now(); end
    end

    serve_to_play(60, "serve3");

    // Rally 3: serve goes left, paddle 1 returns it, paddle 2 misses: player 1 wins 2-1.
    for (int k = 1; k <= 435; k++) begin
      tick();
      if (k == 1)   begin expect_ball(314, 234, "r3_t1"); check_now(); end
      if (k == 118) begin expect_ball(80, 0, "r3_ceiling"); check_now(); end
      if (k == 137) begin expect_ball(42, 38, "r3_t137"); check_now(); end
      if (k == 138) begin expect_ball(40, 40, "r3_hit1"); check_now(); end
      if (k == 139) begin expect_ball(42, 42, "r3_after_hit1"); check_now(); end
      if (k == 354) begin expect_ball(472, 472, "r3_floor"); check_now(); end
      if (k == 414) begin expect_ball(592, 352, "r3_t414"); check_now(); end
      if (k == 434) begin expect_ball(632, 312, "r3_t434"); check_now(); end
      if (k == 435) begin expect_all(0, 0, 316, 236, 2, 1, 3, 1, 1, "r3_win"); check_now(); end
    end

    down1 = 1'b1; down2 = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    expect_all(0, 0, 316, 236, 2, 1, 3, 1, 0, "over_frozen");
    check_now();

    pulse_start(1'b1);
    expect_all(0, 0, 316, 236, 0, 0, 1, 0, 0, "restart_with_tick");
    check_now();
    tick();
    expect_f(F_P1, 4, "restart_p1_moves"); expect_f(F_P2, 4, "restart_p2_moves"); check_now();
    down1 = 1'b0; down2 = 1'b0;
    serve_to_play(59, "serve4");
    up1 = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    @(posedge clk);
    #3 reset = 1'b0;
    expect_all(208, 208, 316, 236, 0, 0, 0, 0, 0, "async_reset");
    check_now();
    #1 reset = 1'b1;
    up1 = 1'b0;
    tick();
    expect_f(F_ST, 0, "post_reset_idle"); check_now();

    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
